fetch_unit: RTL and testbench

Instruction-fetch stage of the single-issue MIPS core. Holds the program counter and drives the word address into the combinational 1 KB instruction memory. Registers each returned instruction, with its PC and PC+4, into the IF/ID pipeline register behind a valid/ready handshake. Supports decode-side stalls, branch/jump redirect with squash, and a sticky fault on misaligned or out-of-range fetch.

---
 rtl/mips_pkg.sv | 17 +
 rtl/fetch_unit_if.sv | 30 +++
 rtl/if_id_reg.sv | 65 ++++++
 rtl/fetch_unit.sv | 107 ++++++++++
 tb/tb_fetch_unit.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core front end.
//   fetch_state_t    : fetch sequencer states (run / halted on fault)
//   RESET_PC_DEFAULT : default program counter after reset
//   INSTR_W, ADDR_W  : instruction and address widths
package mips_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 32;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [0:0] {
        StRun,
        StHalt
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch stage, the instruction memory, the redirect
// source and the decode stage.
//   master : fetch-unit side (drives imem_addr, IF/ID outputs, fault, count)
//   slave  : surrounding core side (drives imem_instr, redirect, out_ready)
interface fetch_unit_if;
    import mips_pkg::*;

    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_instr;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic [ADDR_W-1:0]  out_pc_plus4;
    logic               fault;
    logic [31:0]        fetch_count;

    modport master (
        output imem_addr, out_valid, out_instr, out_pc, out_pc_plus4, fault, fetch_count,
        input  imem_instr, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_addr, out_valid, out_instr, out_pc, out_pc_plus4, fault, fetch_count,
        output imem_instr, redirect_valid, redirect_pc, out_ready
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with a valid/ready output handshake.
//   clk, rst      : clock, asynchronous active-high reset
//   load          : capture in_* and mark valid
//   flush         : drop the held entry (squash)
//   ready         : downstream accepts the entry this cycle
//   in_instr/pc/pc_plus4 : data captured on load
//   valid, instr, pc, pc_plus4 : registered outputs
module if_id_reg
    import mips_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               flush,
    input  logic               ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [ADDR_W-1:0]  in_pc,
    input  logic [ADDR_W-1:0]  in_pc_plus4,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W-1:0]  pc_plus4
);

    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  pc_plus4_q, pc_plus4_d;

    always_comb begin
        instr_d    = instr_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        // Without a load or flush the entry stays until its handshake completes.
        valid_d    = valid_q & ~ready;
        if (load) begin
            valid_d    = 1'b1;
            instr_d    = in_instr;
            pc_d       = in_pc;
            pc_plus4_d = in_pc_plus4;
        end else if (flush) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            instr_q    <= '0;
            pc_q       <= '0;
            pc_plus4_q <= '0;
        end else begin
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
        end
    end

    assign valid    = valid_q;
    assign instr    = instr_q;
    assign pc       = pc_q;
    assign pc_plus4 = pc_plus4_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: program counter, range check, run/halt sequencer
// and the IF/ID register.
//   RESET_PC   : word-aligned PC after reset
//   IMEM_WORDS : instruction memory depth; legal PC is 0 .. IMEM_WORDS*4-4
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : memory, redirect and decode-side signals (master side)
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned       IMEM_WORDS = 256
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);

    // One extra bit so a full 4 GB limit would still be representable.
    localparam logic [ADDR_W:0] PC_LIMIT = {1'b0, ADDR_W'(IMEM_WORDS)} << 2;

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              fault_q, fault_d;
    logic [31:0]       count_q, count_d;

    logic              load;
    logic              flush;
    logic              in_range;
    logic              misaligned;
    logic [ADDR_W-1:0] pc_plus4;

    assign pc_plus4   = pc_q + 32'd4;
    assign in_range   = ({1'b0, pc_q} < PC_LIMIT);
    assign misaligned = |bus.redirect_pc[1:0];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        count_d = count_q;
        load    = 1'b0;
        flush   = 1'b0;
        case (state_q)
            StRun: begin
                if (bus.redirect_valid) begin
                    // Squash regardless of a pending stall; nothing captured.
                    flush = 1'b1;
                    if (misaligned) begin
                        state_d = StHalt;
                        fault_d = 1'b1;
                    end else begin
                        pc_d = bus.redirect_pc;
                    end
                end else if (!in_range) begin
                    // A pending entry still drains through its handshake.
                    state_d = StHalt;
                    fault_d = 1'b1;
                end else if (!bus.out_valid || bus.out_ready) begin
                    load    = 1'b1;
                    pc_d    = pc_plus4;
                    count_d = count_q + 32'd1;
                end
            end
            StHalt: begin
                // Only reset leaves HALT.
            end
            default: begin
                state_d = StHalt;
                fault_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
            count_q <= count_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .flush       (flush),
        .ready       (bus.out_ready),
        .in_instr    (bus.imem_instr),
        .in_pc       (pc_q),
        .in_pc_plus4 (pc_plus4),
        .valid       (bus.out_valid),
        .instr       (bus.out_instr),
        .pc          (bus.out_pc),
        .pc_plus4    (bus.out_pc_plus4)
    );

    assign bus.imem_addr   = pc_q;
    assign bus.fault       = fault_q;
    assign bus.fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic [31:0] mem [256];
    logic [31:0] image [5];

    fetch_unit_if bus ();
    fetch_unit_if sbus ();

    assign bus.redirect_valid = rv;
    assign bus.redirect_pc    = rpc;
    assign bus.out_ready      = rdy;
    assign bus.imem_instr     = (bus.imem_addr < 32'd1024) ? mem[bus.imem_addr[9:2]]
                                                           : 32'hDEAD_BEEF;

    assign sbus.redirect_valid = 1'b0;
    assign sbus.redirect_pc    = 32'd0;
    assign sbus.out_ready      = 1'b1;
    assign sbus.imem_instr     = (sbus.imem_addr < 32'd1024) ? mem[sbus.imem_addr[9:2]]
                                                             : 32'hDEAD_BEEF;

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_WORDS (256)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_WORDS (4)
    ) dut_small (
        .clk (clk),
        .rst (rst),
        .bus (sbus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model of the big instance: architectural view only.
    logic [31:0] m_pc, m_instr, m_opc, m_count;
    logic        m_valid, m_fault;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a < 32'd1024) ? mem[a[9:2]] : 32'hDEAD_BEEF;
    endfunction

    task automatic model_reset();
        m_pc = 32'd0; m_valid = 1'b0; m_instr = 32'd0; m_opc = 32'd0;
        m_fault = 1'b0; m_count = 32'd0;
    endtask

    task automatic model_edge();
        logic handed;
        handed = m_valid && rdy;
        if (m_fault) begin
            if (handed) m_valid = 1'b0;
        end else if (rv) begin
            m_valid = 1'b0;
            if (rpc[1:0] != 2'b00) m_fault = 1'b1;
            else m_pc = rpc;
        end else if (m_pc >= 32'd1024) begin
            m_fault = 1'b1;
            if (handed) m_valid = 1'b0;
        end else if (!m_valid || rdy) begin
            m_instr = mem_word(m_pc);
            m_opc   = m_pc;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
            m_count = m_count + 32'd1;
        end
    endtask

    task automatic compare_all();
        check("imem_addr", bus.imem_addr, m_pc);
        check("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
        check("fault", {31'd0, bus.fault}, {31'd0, m_fault});
        check("fetch_count", bus.fetch_count, m_count);
        if (m_valid) begin
            check("out_instr", bus.out_instr, m_instr);
            check("out_pc", bus.out_pc, m_opc);
            check("out_pc_plus4", bus.out_pc_plus4, m_opc + 32'd4);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1; rv = 1'b0; rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst = 1'b0;
    endtask

    // Called 1 time unit after a rising edge: reset lands between edges.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        check("async_valid", {31'd0, bus.out_valid}, 32'd0);
        check("async_fault", {31'd0, bus.fault}, 32'd0);
        check("async_count", bus.fetch_count, 32'd0);
        check("async_addr", bus.imem_addr, 32'd0);
        model_reset();
        #1 rst = 1'b0;
    endtask

    initial begin
        rv = 1'b0; rpc = 32'd0; rdy = 1'b1;
        image[0] = 32'h20080005; image[1] = 32'h2009000A; image[2] = 32'h01095020;
        image[3] = 32'hAC0A0000; image[4] = 32'h8C0B0000;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        for (int i = 0; i < 5; i++) mem[i] = image[i];

        // Reset values
        repeat (2) @(negedge clk);
        model_reset();
        compare_all();
        check("rst_instr", bus.out_instr, 32'd0);
        check("rst_pc", bus.out_pc, 32'd0);
        check("rst_pc4", bus.out_pc_plus4, 32'd0);
        rst = 1'b0;

        // Reset and stream; small instance runs off its range alongside
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stream_pc", bus.out_pc, 32'(4 * i));
            check("stream_instr", bus.out_instr, image[i]);
            if (i == 3) begin
                check("range_count4", sbus.fetch_count, 32'd4);
                check("range_lastpc", sbus.out_pc, 32'd12);
                check("range_nofault", {31'd0, sbus.fault}, 32'd0);
            end
            if (i == 4) begin
                check("range_fault", {31'd0, sbus.fault}, 32'd1);
                check("range_addr", sbus.imem_addr, 32'd16);
                check("range_count", sbus.fetch_count, 32'd4);
                check("range_valid", {31'd0, sbus.out_valid}, 32'd0);
            end
        end
        check("stream_count", bus.fetch_count, 32'd5);
        tick();
        check("range_hold", sbus.fetch_count, 32'd4);

        // Stall
        do_reset();
        repeat (3) tick();
        check("stall_pc8", bus.out_pc, 32'd8);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_instr", bus.out_instr, 32'h01095020);
            check("stall_addr", bus.imem_addr, 32'd12);
        end
        rdy = 1'b1;
        tick();
        check("resume_pc12", bus.out_pc, 32'd12);
        tick();
        check("resume_pc16", bus.out_pc, 32'd16);
        check("resume_count", bus.fetch_count, 32'd5);

        // Redirect while pc=12 is stalled
        do_reset();
        repeat (4) tick();
        rdy = 1'b0;
        tick();
        check("redir_stalled", bus.out_pc, 32'd12);
        rv = 1'b1; rpc = 32'd4;
        tick();
        check("redir_bubble", {31'd0, bus.out_valid}, 32'd0);
        rv = 1'b0; rdy = 1'b1;
        tick();
        check("redir_pc", bus.out_pc, 32'd4);
        check("redir_instr", bus.out_instr, 32'h2009000A);

        // Misaligned redirect, later redirects ignored
        rv = 1'b1; rpc = 32'd6;
        tick();
        check("mis_fault", {31'd0, bus.fault}, 32'd1);
        check("mis_valid", {31'd0, bus.out_valid}, 32'd0);
        rpc = 32'd8;
        repeat (3) begin
            tick();
            check("halt_fault", {31'd0, bus.fault}, 32'd1);
            check("halt_addr", bus.imem_addr, 32'd8);
        end
        rv = 1'b0;

        // Async reset mid-stream
        do_reset();
        repeat (3) tick();
        async_reset();
        repeat (2) tick();

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 500; c++) begin
            rdy = ($urandom % 4) != 0;
            rv  = ($urandom % 12) == 0;
            if (($urandom % 16) == 0) rpc = {$urandom_range(0, 255), 2'b00} | 32'($urandom_range(1, 3));
            else rpc = {22'd0, 8'($urandom_range(0, 255)), 2'b00} + (($urandom % 10 == 0) ? 32'd1024 : 32'd0);
            tick();
            if ((m_fault && ($urandom % 6) == 0) || ($urandom % 150) == 0) async_reset();
        end
        rv = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
